// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: funnels NCH request channels onto one downstream memory port.
// One transaction is outstanding at a time. The winning channel's request is
// captured into registers, and the memory side is driven only from those
// registers until mem_hit completes it.
// Optional feature macro: ARB_RR_EN. When it is defined, arbitration is
// round-robin. When it is undefined, the lowest-index requester always wins.
module mem_req_arbiter #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NCH-1:0]   ch_ren,
  input  logic [NCH-1:0]   ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_store,
  output logic [NCH-1:0]   ch_hit,
  output logic [DW-1:0]    ch_load,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_store,
  input  logic             mem_hit,
  input  logic [DW-1:0]    mem_load
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [NCH-1:0]  req;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  logic            wr_sel;
  logic [AW-1:0]   addr_sel;
  logic [DW-1:0]   store_sel;

  assign req = ch_ren | ch_wen;

`ifdef ARB_RR_EN
  logic [GW-1:0]   ptr;
  int unsigned     idx;

  // Round-robin pick: scan starting at the pointer and wrap at NCH
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_valid && req[GW'(idx)]) begin
        pick       = GW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  // Pointer moves just past the completed grant at the completion edge
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
    end else if (state == BUSY && mem_hit) begin
      ptr <= (32'(grant) + 32'd1 >= NCH) ? '0 : GW'(32'(grant) + 32'd1);
    end
  end
`else
  // Fixed priority pick: the lowest-index requester wins
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!pick_valid && req[GW'(i)]) begin
        pick       = GW'(i);
        pick_valid = 1'b1;
      end
    end
  end
`endif

  // Extract the selected channel's fields from the flattened buses
  always_comb begin
    wr_sel    = |(ch_wen & (NCH'(1) << pick));
    addr_sel  = AW'(ch_addr >> (32'(pick) * AW));
    store_sel = DW'(ch_store >> (32'(pick) * DW));
  end

  // FSM, capture registers and registered memory strobes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      grant     <= '0;
      mem_addr  <= '0;
      mem_store <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= BUSY;
            grant     <= pick;
            mem_addr  <= addr_sel;
            mem_store <= store_sel;
            mem_wen   <= wr_sel;
            mem_ren   <= ~wr_sel;
          end
        end
        BUSY: begin
          if (mem_hit) begin
            state   <= IDLE;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
        end
      endcase
    end
  end

  // Completion pulse to the granted channel in the mem_hit cycle
  always_comb begin
    ch_hit = (state == BUSY && mem_hit) ? (NCH'(1) << grant) : '0;
  end

  assign ch_load = mem_load;

endmodule
